// File: rtl/ibex_xif_pkg.sv
// Dummy-instruction encoding shared by the dummy inserter and the retirement checker.
// Both sides build on these constants, so the encoder and the decoder cannot diverge.
package ibex_xif_pkg;

  typedef enum logic [1:0] {
    DummyAdd,
    DummyMul,
    DummyDiv,
    DummyAnd
  } dummy_instr_e;

  localparam logic [6:0] DummyOpcode    = 7'h33;
  localparam logic [6:0] DummyFunct7Add = 7'h00;
  localparam logic [6:0] DummyFunct7Mul = 7'h01;
  localparam logic [6:0] DummyFunct7Div = 7'h01;
  localparam logic [6:0] DummyFunct7And = 7'h00;
  localparam logic [2:0] DummyFunct3Add = 3'b000;
  localparam logic [2:0] DummyFunct3Mul = 3'b000;
  localparam logic [2:0] DummyFunct3Div = 3'b100;
  localparam logic [2:0] DummyFunct3And = 3'b111;

  // Fields that must match exactly: funct7, funct3, rd and opcode. rs1/rs2 are free.
  localparam logic [31:0] DummyMask = 32'hFE00_7FFF;

  function automatic logic [9:0] dummy_instr_funct(dummy_instr_e sel);
    logic [9:0] funct;
    unique case (sel)
      DummyAdd: funct = {DummyFunct7Add, DummyFunct3Add};
      DummyMul: funct = {DummyFunct7Mul, DummyFunct3Mul};
      DummyDiv: funct = {DummyFunct7Div, DummyFunct3Div};
      default:  funct = {DummyFunct7And, DummyFunct3And};
    endcase
    return funct;
  endfunction

  function automatic logic [31:0] dummy_instr_encode(dummy_instr_e sel, logic [4:0] rs1,
                                                     logic [4:0] rs2);
    logic [9:0] funct;
    funct = dummy_instr_funct(sel);
    return {funct[9:3], rs2, rs1, funct[2:0], 5'd0, DummyOpcode};
  endfunction

  function automatic logic dummy_instr_legal(logic [31:0] instr);
    logic [31:0] masked;
    masked = instr & DummyMask;
    return (masked == dummy_instr_encode(DummyAdd, 5'd0, 5'd0)) ||
           (masked == dummy_instr_encode(DummyMul, 5'd0, 5'd0)) ||
           (masked == dummy_instr_encode(DummyDiv, 5'd0, 5'd0)) ||
           (masked == dummy_instr_encode(DummyAnd, 5'd0, 5'd0));
  endfunction

endpackage

// File: rtl/ibex_xif_dummy_tag_fifo.sv
// One-bit-wide tag FIFO tracking whether each in-flight instruction is a dummy.
// Flush wins over push/pop; push is accepted when full only together with a pop.
module ibex_xif_dummy_tag_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  logic tag_i,
  input  logic pop_i,
  output logic head_o,
  output logic empty_o,
  output logic full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Depth-1:0] tags_q, tags_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign head_o  = tags_q[rptr_q[PtrW-1:0]];

  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    tags_d = tags_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) begin
        tags_d[wptr_q[PtrW-1:0]] = tag_i;
        wptr_d = wptr_q + PtrOne;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      tags_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      tags_q <= tags_d;
    end
  end

endmodule

// File: rtl/ibex_xif_dummy_instr_checker.sv
// Tags in-flight instructions as dummy/real, qualifies instret, counts retired dummies
// and raises a sticky alert on malformed dummies or tag-tracking inconsistencies.
module ibex_xif_dummy_instr_checker
  import ibex_xif_pkg::*;
#(
  parameter int unsigned TagDepth = 4,
  parameter int unsigned CntW     = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dummy_instr_en_i,
  input  logic            issue_valid_i,
  input  logic            issue_is_dummy_i,
  input  logic [31:0]     issue_instr_i,
  input  logic            retire_valid_i,
  input  logic            flush_i,
  output logic            retire_is_dummy_o,
  output logic            instret_inc_o,
  output logic [CntW-1:0] dummy_cnt_o,
  output logic            alert_o
);

  logic            head, empty, full;
  logic            dummy_issue, bad_encoding, bad_enable, underflow, overflow;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            alert_q, alert_d;

  ibex_xif_dummy_tag_fifo #(
    .Depth (TagDepth)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (issue_valid_i),
    .tag_i   (issue_is_dummy_i),
    .pop_i   (retire_valid_i),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full)
  );

  assign retire_is_dummy_o = retire_valid_i & ~empty & head;
  assign instret_inc_o     = retire_valid_i & ~empty & ~head;

  assign dummy_issue  = issue_valid_i & issue_is_dummy_i;
  assign bad_encoding = dummy_issue & ~dummy_instr_legal(issue_instr_i);
  assign bad_enable   = dummy_issue & ~dummy_instr_en_i;
  assign underflow    = retire_valid_i & empty;
  assign overflow     = issue_valid_i & full & ~retire_valid_i;

  // A flush discards the same-cycle push and pop, so neither may count or alert.
  always_comb begin
    alert_d = alert_q;
    cnt_d   = cnt_q;
    if (!flush_i) begin
      alert_d = alert_q | bad_encoding | bad_enable | underflow | overflow;
      if (retire_is_dummy_o && (cnt_q != {CntW{1'b1}})) begin
        cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      alert_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alert_q <= alert_d;
    end
  end

  assign dummy_cnt_o = cnt_q;
  assign alert_o     = alert_q;

endmodule

// File: tb/tb_ibex_xif_dummy_instr_checker.sv
// Self-checking bench: scoreboard of in-flight tags plus a table of dummy encodings.
module tb_ibex_xif_dummy_instr_checker;

  localparam int Depth = 4;
  localparam logic [31:0] WAdd  = 32'h00A5_0033;
  localparam logic [31:0] WReal = 32'h00B5_0533;
  localparam logic [31:0] WSll  = 32'h00A5_1033;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, iv = 1'b0, idum = 1'b0, rv = 1'b0, fl = 1'b0;
  logic [31:0] instr = '0;
  logic        rd1, inc1, al1, rd2, inc2, al2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          sb_q[$];
  bit          exp_alert;
  int unsigned exp_cnt;

  always #5 clk = ~clk;

  ibex_xif_dummy_instr_checker dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .dummy_instr_en_i  (en),
    .issue_valid_i     (iv),
    .issue_is_dummy_i  (idum),
    .issue_instr_i     (instr),
    .retire_valid_i    (rv),
    .flush_i           (fl),
    .retire_is_dummy_o (rd1),
    .instret_inc_o     (inc1),
    .dummy_cnt_o       (cnt1),
    .alert_o           (al1)
  );

  ibex_xif_dummy_instr_checker #(
    .TagDepth (4),
    .CntW     (4)
  ) dut4 (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .dummy_instr_en_i  (en),
    .issue_valid_i     (iv),
    .issue_is_dummy_i  (idum),
    .issue_instr_i     (instr),
    .retire_valid_i    (rv),
    .flush_i           (fl),
    .retire_is_dummy_o (rd2),
    .instret_inc_o     (inc2),
    .dummy_cnt_o       (cnt2),
    .alert_o           (al2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check combinational retire outputs, update model, check registered state.
  task automatic step(input bit iv_in, input bit dum_in, input logic [31:0] w, input bit rv_in,
                      input bit fl_in, input bit bad);
    int old_size;
    bit exp_rd, exp_inc;
    iv = iv_in; idum = dum_in; instr = w; rv = rv_in; fl = fl_in;
    #1;
    old_size = sb_q.size();
    exp_rd  = rv_in && (old_size > 0) && sb_q[0];
    exp_inc = rv_in && (old_size > 0) && !sb_q[0];
    check("retire_is_dummy", rd1, exp_rd);
    check("instret_inc", inc1, exp_inc);
    check("retire_is_dummy_c4", rd2, exp_rd);
    check("instret_inc_c4", inc2, exp_inc);
    if (fl_in) begin
      sb_q.delete();
    end else begin
      if (bad) exp_alert = 1'b1;
      if (rv_in && old_size == 0) exp_alert = 1'b1;
      if (iv_in && old_size == Depth && !rv_in) exp_alert = 1'b1;
      if (exp_rd) exp_cnt++;
      if (rv_in && old_size > 0) void'(sb_q.pop_front());
      if (iv_in && (old_size < Depth || rv_in)) sb_q.push_back(dum_in);
    end
    @(negedge clk);
    iv = 1'b0; idum = 1'b0; instr = '0; rv = 1'b0; fl = 1'b0;
    check("alert", al1, exp_alert);
    check("alert_c4", al2, exp_alert);
    check("dummy_cnt", cnt1, (exp_cnt > 16'hFFFF) ? 16'hFFFF : exp_cnt);
    check("dummy_cnt_c4", cnt2, (exp_cnt > 15) ? 15 : exp_cnt);
  endtask

  // Asynchronous reset asserted mid-cycle, with a retire request pending.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    rv = 1'b1;
    #1;
    check("rst_retire_is_dummy", rd1, 0);
    check("rst_instret_inc", inc1, 0);
    check("rst_alert", al1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_cnt_c4", cnt2, 0);
    check("rst_alert_c4", al2, 0);
    rv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    exp_alert = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic basic_seq();
    en = 1'b1;
    step(1, 0, WReal, 0, 0, 0);
    step(1, 1, WAdd, 0, 0, 0);
    step(1, 0, WReal, 0, 0, 0);
    repeat (3) step(0, 0, '0, 1, 0, 0);
    check("basic_cnt", cnt1, 1);
    check("basic_alert", al1, 0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] w;
    bit          dummy;
    bit          en;
    bit          bad;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"add",        32'h00A5_0033, 1, 1, 0};
    vecs[1] = '{"mul",        32'h02A5_0033, 1, 1, 0};
    vecs[2] = '{"div",        32'h02A5_4033, 1, 1, 0};
    vecs[3] = '{"and",        32'h00A5_7033, 1, 1, 0};
    vecs[4] = '{"add_rs",     32'h01F0_8033, 1, 1, 0};
    vecs[5] = '{"sll",        WSll,          1, 1, 1};
    vecs[6] = '{"rd1",        32'h00A5_00B3, 1, 1, 1};
    vecs[7] = '{"sub",        32'h40A5_0033, 1, 1, 1};
    vecs[8] = '{"addi",       32'h00A5_0013, 1, 1, 1};
    vecs[9] = '{"dummy_off",  32'h00A5_0033, 1, 0, 1};

    do_reset();
    basic_seq();

    foreach (vecs[i]) begin
      do_reset();
      en = vecs[i].en;
      step(1, vecs[i].dummy, vecs[i].w, 0, 0, vecs[i].bad);
      step(0, 0, '0, 1, 0, 0);
    end

    // Real instruction with dummies disabled must not alert.
    do_reset();
    en = 1'b0;
    step(1, 0, WSll, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0);

    // Illegal dummy: alert one cycle later, then sticky.
    do_reset();
    en = 1'b1;
    step(1, 1, WSll, 0, 0, 1);
    repeat (100) step(0, 0, '0, 0, 0, 0);

    // Full FIFO: push+pop keeps occupancy, lone push overflows and is dropped.
    do_reset();
    en = 1'b1;
    step(1, 1, WAdd, 0, 0, 0);
    step(1, 0, WReal, 0, 0, 0);
    step(1, 1, WAdd, 0, 0, 0);
    step(1, 0, WReal, 0, 0, 0);
    step(1, 1, WAdd, 1, 0, 0);
    check("full_pushpop_alert", al1, 0);
    step(1, 0, WReal, 0, 0, 0);
    check("overflow_alert", al1, 1);
    repeat (5) step(0, 0, '0, 1, 0, 0);

    // Flush with simultaneous issue and retire.
    do_reset();
    en = 1'b1;
    repeat (3) step(1, 1, WAdd, 0, 0, 0);
    step(1, 1, WAdd, 1, 1, 0);
    check("flush_cnt", cnt1, 0);
    check("flush_alert", al1, 0);
    step(0, 0, '0, 1, 0, 0);
    check("post_flush_underflow", al1, 1);

    // Counter saturation on the narrow-counter instance.
    do_reset();
    en = 1'b1;
    repeat (18) begin
      step(1, 1, WAdd, 0, 0, 0);
      step(0, 0, '0, 1, 0, 0);
    end
    check("sat_cnt_c4", cnt2, 4'hF);
    check("sat_cnt", cnt1, 18);

    // Reset mid-operation with entries queued and alert set.
    do_reset();
    en = 1'b1;
    step(1, 1, WAdd, 0, 0, 0);
    step(1, 0, WReal, 0, 0, 0);
    step(1, 1, WSll, 0, 0, 1);
    do_reset();
    basic_seq();

    // After reset, a retire with nothing issued underflows.
    do_reset();
    step(0, 0, '0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
